// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared FSM state encoding and pin-protocol constants for the UART pin scheduler.
//   Toggle masks are XORed into the wrapper's control[3:2] direction bits to encode one command.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_HOLD,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [1:0] TGL_NONE = 2'b00;
    localparam logic [1:0] TGL_WR   = 2'b01;
    localparam logic [1:0] TGL_RD   = 2'b10;
    localparam logic [1:0] TGL_CLR  = 2'b11;
    localparam logic [1:0] RATE_OFF = 2'b00;

endpackage

// File: rtl/uart_pin_scheduler_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with a priority-override subset.
//   clk, reset : clock, synchronous active-high reset
//   i_req      : request vector
//   i_pri      : requests eligible for override (e.g. reads)
//   i_pri_en   : when set and any eligible request is pending, only those compete
//   i_accept   : grant is consumed this cycle; advance the pointer
//   o_gnt      : one-hot grant (zero when nothing requests)
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic [1:0] i_pri,
    input  logic       i_pri_en,
    input  logic       i_accept,
    output logic [1:0] o_gnt
);

    logic       r_ptr;
    logic [1:0] w_pri_req;
    logic [1:0] w_cand;

    assign w_pri_req = i_req & i_pri;
    assign w_cand    = (i_pri_en && |w_pri_req) ? w_pri_req : i_req;
    // Contention is resolved by the pointer; a single candidate wins outright.
    assign o_gnt     = (&w_cand) ? (r_ptr ? 2'b10 : 2'b01) : w_cand;

    // The pointer moves past whichever requester was just granted.
    always_ff @(posedge clk) begin
        if (reset)
            r_ptr <= 1'b0;
        else if (i_accept && |o_gnt)
            r_ptr <= o_gnt[0];
    end

endmodule

// File: rtl/uart_pin_scheduler.sv
// uart_pin_scheduler: shares the UART wrapper pin interface between two requesters plus a config port.
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/write/wdata : per-requester byte read/write requests; req_ready pulses on grant
//   rsp_valid/rdata/err : per-requester completion pulse, read data and error flag
//   cfg_valid/clear/rate_sel : FIFO clear or rate-select command; cfg_ready pulses on accept
//   uart_control        : [3:2] toggle-encoded direction bits, [1:0] rate select
//   uart_tx_data        : byte to the wrapper; uart_rx_data/rts/err sampled from it
//   busy                : a command is in flight
module uart_pin_scheduler
    import uart_sched_pkg::*;
#(
    parameter logic [1:0] DefaultRateSel = 2'b01,
    parameter int         ReadLatency    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_write,
    input  logic [15:0] req_wdata,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    input  logic        cfg_valid,
    input  logic        cfg_clear,
    input  logic [1:0]  cfg_rate_sel,
    output logic        cfg_ready,
    output logic [3:0]  uart_control,
    output logic [7:0]  uart_tx_data,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rts,
    input  logic        uart_err,
    output logic        busy
);

    // Last WAIT count before CAPTURE; unused when ReadLatency is 2 (WAIT is skipped).
    localparam logic [7:0] WAIT_LAST = 8'(ReadLatency - 3);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_dir;
    logic [1:0]  r_rate;
    logic [7:0]  r_cnt;
    logic        r_who;
    logic        r_write;
    logic        r_cfg;
    logic        r_zero;
    logic [7:0]  r_byte;
    logic [1:0]  w_gnt;
    logic [1:0]  w_who_mask;
    logic [7:0]  w_byte;
    logic        w_wr;
    logic        w_accept;
    logic        w_zero_wr;

    assign w_accept     = (r_state == S_IDLE) && !cfg_valid;
    assign w_byte       = w_gnt[1] ? req_wdata[15:8] : req_wdata[7:0];
    assign w_wr         = |(w_gnt & req_write);
    // The wrapper drops zero bytes, so such writes complete with an error and never touch the pins.
    assign w_zero_wr    = w_wr && (w_byte == 8'h00);
    assign w_who_mask   = {r_who, ~r_who};
    assign uart_control = {r_dir, r_rate};
    assign busy         = (r_state != S_IDLE);

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .i_req    (req_valid),
        .i_pri    (~req_write),
        .i_pri_en (uart_rts),
        .i_accept (w_accept),
        .o_gnt    (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_dir   <= 2'b00;
            r_rate  <= DefaultRateSel;
            r_cnt   <= 8'd0;
            r_who   <= 1'b0;
            r_write <= 1'b0;
            r_cfg   <= 1'b0;
            r_zero  <= 1'b0;
            r_byte  <= 8'h00;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == S_WAIT) ? r_cnt + 8'd1 : 8'd0;
            // Pin effects are registered on the grant edge so they appear in the ISSUE cycle.
            if (r_state == S_IDLE && cfg_valid) begin
                r_cfg   <= 1'b1;
                r_write <= 1'b0;
                r_zero  <= 1'b0;
                r_byte  <= 8'h00;
                r_dir   <= r_dir ^ (cfg_clear ? TGL_CLR : TGL_NONE);
                if (!cfg_clear && cfg_rate_sel != RATE_OFF)
                    r_rate <= cfg_rate_sel;
            end else if (w_accept && |w_gnt) begin
                r_cfg   <= 1'b0;
                r_who   <= w_gnt[1];
                r_write <= w_wr;
                r_byte  <= w_byte;
                r_zero  <= w_zero_wr;
                if (!w_zero_wr)
                    r_dir <= r_dir ^ (w_wr ? TGL_WR : TGL_RD);
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        req_ready    = 2'b00;
        cfg_ready    = 1'b0;
        rsp_valid    = 2'b00;
        rsp_rdata    = 8'h00;
        rsp_err      = 1'b0;
        uart_tx_data = 8'h00;
        case (r_state)
            S_IDLE: begin
                cfg_ready = cfg_valid;
                req_ready = cfg_valid ? 2'b00 : w_gnt;
                if (cfg_valid)
                    w_next = S_ISSUE;
                else if (|w_gnt)
                    w_next = w_zero_wr ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                uart_tx_data = r_write ? r_byte : 8'h00;
                w_next       = S_HOLD;
            end
            S_HOLD: begin
                uart_tx_data = r_write ? r_byte : 8'h00;
                w_next       = (r_cfg || r_write) ? S_DONE : (ReadLatency == 2 ? S_CAPTURE : S_WAIT);
            end
            S_WAIT: begin
                w_next = (r_cnt == WAIT_LAST) ? S_CAPTURE : S_WAIT;
            end
            S_CAPTURE: begin
                rsp_valid = w_who_mask;
                rsp_rdata = uart_rx_data;
                // An empty RX FIFO reads back as zero.
                rsp_err   = uart_err || (uart_rx_data == 8'h00);
                w_next    = S_IDLE;
            end
            S_DONE: begin
                rsp_valid = r_cfg ? 2'b00 : w_who_mask;
                rsp_err   = !r_cfg && (uart_err || r_zero);
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_pin_scheduler.sv
// tb_uart_pin_scheduler: directed self-checking bench for uart_pin_scheduler (latency 2 and 3 instances).
module tb_uart_pin_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [15:0] req_wdata;
    logic        cfg_valid;
    logic        cfg_clear;
    logic [1:0]  cfg_rate_sel;
    logic [7:0]  uart_rx_data;
    logic        uart_rts;
    logic        uart_err;

    logic [1:0]  req_ready,  req_ready3;
    logic [1:0]  rsp_valid,  rsp_valid3;
    logic [7:0]  rsp_rdata,  rsp_rdata3;
    logic        rsp_err,    rsp_err3;
    logic        cfg_ready,  cfg_ready3;
    logic [3:0]  uart_control, uart_control3;
    logic [7:0]  uart_tx_data, uart_tx_data3;
    logic        busy,       busy3;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_pin_scheduler #(.DefaultRateSel(2'b01), .ReadLatency(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cfg_valid(cfg_valid), .cfg_clear(cfg_clear), .cfg_rate_sel(cfg_rate_sel), .cfg_ready(cfg_ready),
        .uart_control(uart_control), .uart_tx_data(uart_tx_data), .uart_rx_data(uart_rx_data),
        .uart_rts(uart_rts), .uart_err(uart_err), .busy(busy)
    );

    uart_pin_scheduler #(.DefaultRateSel(2'b01), .ReadLatency(3)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_wdata(req_wdata),
        .req_ready(req_ready3), .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
        .cfg_valid(cfg_valid), .cfg_clear(cfg_clear), .cfg_rate_sel(cfg_rate_sel), .cfg_ready(cfg_ready3),
        .uart_control(uart_control3), .uart_tx_data(uart_tx_data3), .uart_rx_data(uart_rx_data),
        .uart_rts(uart_rts), .uart_err(uart_err), .busy(busy3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 2'b00; req_write = 2'b00; req_wdata = 16'h0000;
        cfg_valid = 1'b0; cfg_clear = 1'b0; cfg_rate_sel = 2'b00;
        uart_rx_data = 8'h00; uart_rts = 1'b0; uart_err = 1'b0;
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst_control", 16'(uart_control), 16'h1);
        chk("rst_req_ready", 16'(req_ready), 16'h0);
        chk("rst_rsp_valid", 16'(rsp_valid), 16'h0);
        chk("rst_cfg_ready", 16'(cfg_ready), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_tx", 16'(uart_tx_data), 16'h0);

        // requester 0 writes 0x41
        req_valid = 2'b01; req_write = 2'b01; req_wdata = 16'h0041;
        #1;
        chk("wr_grant", 16'(req_ready), 16'h1);
        step(); req_valid = 2'b00; #1;
        chk("wr_toggle", 16'(uart_control), 16'h5);
        chk("wr_tx_issue", 16'(uart_tx_data), 16'h41);
        chk("wr_busy", 16'(busy), 16'h1);
        step();
        chk("wr_tx_hold", 16'(uart_tx_data), 16'h41);
        chk("wr_no_early_rsp", 16'(rsp_valid), 16'h0);
        step();
        chk("wr_rsp", 16'(rsp_valid), 16'h1);
        chk("wr_err", 16'(rsp_err), 16'h0);
        chk("wr_tx_done", 16'(uart_tx_data), 16'h0);
        step();
        chk("wr_idle", 16'(busy), 16'h0);

        // requester 1 reads 0x5A
        req_valid = 2'b10; req_write = 2'b00; uart_rx_data = 8'h5A;
        #1;
        chk("rd_grant", 16'(req_ready), 16'h2);
        step(); req_valid = 2'b00; #1;
        chk("rd_toggle", 16'(uart_control), 16'hD);
        step(); step();
        chk("rd_rsp", 16'(rsp_valid), 16'h2);
        chk("rd_data", 16'(rsp_rdata), 16'h5A);
        chk("rd_err", 16'(rsp_err), 16'h0);
        step();

        // requester 1 reads an empty FIFO
        req_valid = 2'b10; uart_rx_data = 8'h00;
        step(); req_valid = 2'b00; #1;
        chk("rd0_toggle", 16'(uart_control), 16'h5);
        step(); step();
        chk("rd0_rsp", 16'(rsp_valid), 16'h2);
        chk("rd0_err", 16'(rsp_err), 16'h1);
        step();

        // both requesters write continuously: grants alternate 0,1,0,1
        req_valid = 2'b11; req_write = 2'b11; req_wdata = 16'h2211;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_grant", 16'(req_ready), (i % 2 == 0) ? 16'h1 : 16'h2);
            step();
            chk("rr_tx", 16'(uart_tx_data), (i % 2 == 0) ? 16'h11 : 16'h22);
            step(); step();
            chk("rr_rsp", 16'(rsp_valid), (i % 2 == 0) ? 16'h1 : 16'h2);
            step();
        end
        req_valid = 2'b00;
        chk("rr_control", 16'(uart_control), 16'h5);

        // rts: req1 read beats req0 write even with the pointer at 0
        uart_rts = 1'b1; req_valid = 2'b11; req_write = 2'b01; req_wdata = 16'h0033; uart_rx_data = 8'h77;
        #1;
        chk("rts_grant", 16'(req_ready), 16'h2);
        step(); req_valid = 2'b00; uart_rts = 1'b0; #1;
        chk("rts_toggle", 16'(uart_control), 16'hD);
        step(); step();
        chk("rts_rsp", 16'(rsp_valid), 16'h2);
        chk("rts_data", 16'(rsp_rdata), 16'h77);
        step();

        // cfg rate 11 alongside a request: cfg wins
        cfg_valid = 1'b1; cfg_clear = 1'b0; cfg_rate_sel = 2'b11;
        req_valid = 2'b01; req_write = 2'b01; req_wdata = 16'h0044;
        #1;
        chk("cfg_ready", 16'(cfg_ready), 16'h1);
        chk("cfg_beats_req", 16'(req_ready), 16'h0);
        step(); cfg_valid = 1'b0; req_valid = 2'b00; #1;
        chk("cfg_rate", 16'(uart_control), 16'hF);
        step(); step();
        chk("cfg_no_rsp", 16'(rsp_valid), 16'h0);
        step();

        // cfg clear flips both direction bits
        cfg_valid = 1'b1; cfg_clear = 1'b1;
        #1;
        chk("clr_ready", 16'(cfg_ready), 16'h1);
        step(); cfg_valid = 1'b0; #1;
        chk("clr_toggle", 16'(uart_control), 16'h3);
        step(); step(); step();
        chk("clr_idle", 16'(busy), 16'h0);

        // rate 00 is accepted but ignored
        cfg_valid = 1'b1; cfg_clear = 1'b0; cfg_rate_sel = 2'b00;
        step(); cfg_valid = 1'b0; #1;
        chk("rate00_kept", 16'(uart_control), 16'h3);
        step(); step(); step();

        // write of zero: no toggle, error response
        req_valid = 2'b10; req_write = 2'b10; req_wdata = 16'h0000;
        #1;
        chk("wz_grant", 16'(req_ready), 16'h2);
        step(); req_valid = 2'b00; #1;
        chk("wz_rsp", 16'(rsp_valid), 16'h2);
        chk("wz_err", 16'(rsp_err), 16'h1);
        chk("wz_no_toggle", 16'(uart_control), 16'h3);
        step();
        chk("wz_idle", 16'(busy), 16'h0);

        // latency-3 instance: read timing, then reset during WAIT
        reset = 1'b1; step(); reset = 1'b0;
        req_valid = 2'b01; req_write = 2'b00; uart_rx_data = 8'h3C;
        #1;
        chk("l3_grant", 16'(req_ready3), 16'h1);
        step(); req_valid = 2'b00; step(); step();
        chk("l3_wait_no_rsp", 16'(rsp_valid3), 16'h0);
        chk("l3_wait_busy", 16'(busy3), 16'h1);
        step();
        chk("l3_rsp", 16'(rsp_valid3), 16'h1);
        chk("l3_data", 16'(rsp_rdata3), 16'h3C);
        step();
        req_valid = 2'b01;
        step(); req_valid = 2'b00; step(); step();
        reset = 1'b1; #1;
        chk("rstw_no_rsp", 16'(rsp_valid3), 16'h0);
        step(); reset = 1'b0; #1;
        chk("rstw_idle", 16'(busy3), 16'h0);
        chk("rstw_no_rsp_after", 16'(rsp_valid3), 16'h0);
        chk("rstw_control", 16'(uart_control3), 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_pin_scheduler.md
# uart_pin_scheduler

- Shares the UART tapeout wrapper's narrow pin interface between two on-chip requesters, and accepts baud-select and FIFO-clear commands.
- Sits between the requesters and the wrapper, driving the wrapper's `control[3:0]` and `tx_data[7:0]` and sampling its `rx_data[7:0]`, `rts` and `err`.
- Converts byte read/write requests into the wrapper's toggle-encoded direction protocol, arbitrates round-robin, and returns read data with fixed latency.

## Interface
Parameters:
- `DefaultRateSel`, 2'b01: rate field driven out of reset. 2'b00 is illegal because it zeroes the wrapper's baud rate.
- `ReadLatency`, 2: cycles from the read-issue cycle to the cycle in which `uart_rx_data` is valid. Minimum 2.

Ports:
- `clk`  in  1  single clock
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  2  per-requester request
- `req_write`  in  2  1 = write byte, 0 = read byte
- `req_wdata`  in  16  requester n byte at [8n+7:8n]
- `req_ready`  out  2  one-cycle grant pulse; request consumed
- `rsp_valid`  out  2  one-cycle completion pulse to requester n
- `rsp_rdata`  out  8  read data; valid with `rsp_valid`
- `rsp_err`  out  1  completion flag; valid with `rsp_valid`
- `cfg_valid`  in  1  config command
- `cfg_clear`  in  1  1 = clear both wrapper FIFOs, 0 = set rate
- `cfg_rate_sel`  in  2  new rate field
- `cfg_ready`  out  1  one-cycle accept pulse
- `uart_control`  out  4  [3:2] direction toggles, [1:0] rate select
- `uart_tx_data`  out  8  byte to the wrapper
- `uart_rx_data`  in  8  byte from the wrapper
- `uart_rts`  in  1  wrapper RX FIFO full
- `uart_err`  in  1  wrapper sticky error
- `busy`  out  1  state != IDLE

## Operation
Pin protocol:
- The wrapper decodes the XOR of consecutive `control[3:2]` values, so commands are level toggles:
  - write = flip bit 2
  - read = flip bit 3
  - clear = flip both bits
- The direction bits are never restored afterwards; they hold their level until the next command.

States:
- **IDLE**
  - Priority: cfg > requesters.
  - Between requesters, round-robin: the pointer moves past the last granted requester.
  - If `uart_rts`=1, pending reads win over pending writes, regardless of the pointer.
  - On grant, pulse `req_ready[n]` or `cfg_ready` in this cycle and go to ISSUE.
- **ISSUE** (1 cycle)
  - Toggle the direction bits per the command.
  - For a write, drive `uart_tx_data` = byte.
  - For a rate command, update `control[1:0]`.
- **HOLD** (1 cycle)
  - Keep `uart_tx_data` = byte; the wrapper samples it here.
  - Writes, rate and clear commands go to DONE.
  - Reads go to WAIT.
- **WAIT** (ReadLatency-2 cycles; skipped when 0), then CAPTURE.
- **CAPTURE**
  - Sample `uart_rx_data`.
  - Pulse `rsp_valid[n]`.
  - `rsp_rdata` = sample.
  - `rsp_err` = `uart_err` OR (sample == 0). Zero means the RX FIFO was empty.
- **DONE**
  - Write: pulse `rsp_valid[n]`, `rsp_err` = `uart_err`.
  - Config: no response.
  - Then go to IDLE. `uart_tx_data` = 0.

Boundary rules:
- Write of 0x00: the wrapper drops zero bytes, so this write is not issued. IDLE→DONE, no toggle, `rsp_err`=1.
- `cfg_rate_sel` = 2'b00: accepted but ignored; rate unchanged.
- Requests arriving while busy wait; `req_valid` must hold until `req_ready`.
- `reset` mid-operation:
  - Abandon the operation with no response.
  - Do not restore the direction bits; a pending wrapper-side effect completes.
- All outputs after reset: `uart_control` = {2'b00, DefaultRateSel}; every other output 0; RR pointer → requester 0.

## Timing
- Write: grant at cycle t, toggle at t+1, data held t+1..t+2, `rsp_valid` at t+3. Back-to-back issue period is 4 cycles.
- Read: toggle at t+1, CAPTURE at t+1+ReadLatency, `rsp_valid` in that same cycle.
- Rate: new `control[1:0]` visible at t+1; the wrapper uses it from t+2.
- At most one command in flight; no pipelining.

## Structure
- `uart_sched_pkg`:
  - state enum (IDLE, ISSUE, HOLD, WAIT, CAPTURE, DONE)
  - toggle masks: WR=2'b01, RD=2'b10, CLR=2'b11
  - `RATE_OFF`=2'b00
- Sub-module `rr_arb2`:
  - 2-way round-robin with a priority-override input (read-first on `rts`)
  - outputs a one-hot grant and updates its pointer on accept

## Test plan
- Reset: `uart_control`=4'b0001, all handshake outputs 0.
- Requester 0 writes 0x41: direction toggles 00→01, `uart_tx_data`=0x41 for 2 cycles, `rsp_valid`=2'b01 three cycles after grant, `rsp_err`=0.
- Requester 1 reads with `uart_rx_data`=0x5A at latency 2: direction toggles 01→11, CAPTURE returns 0x5A, `rsp_valid`=2'b10. With rx 0x00, `rsp_err`=1.
- Both requesters hold requests for 4 grants: grants alternate 0,1,0,1. With `uart_rts`=1, req1 reading and req0 writing, req1 is granted first.
- cfg rate 2'b11 then cfg clear:
  - `control[1:0]`→11.
  - Both direction bits flip.
  - A cfg asserted alongside `req_valid` wins.
  - Rate 2'b00 leaves the field at 11.
- Write 0x00 → no toggle, `rsp_err`=1. Reset during WAIT → no `rsp_valid`, IDLE next cycle.
